// File: rtl/seg7_update_sequencer.sv
// Bus-master write sequencer for the memory-mapped seven-segment display controller.
// Optional macro SEG7_UPDATE_SKIP_UNCHANGED_EN: skip digits whose value already matches the display.
module seg7_update_sequencer #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'hc0001000,
    parameter int                    NUM_7SEGMENTS = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [4*NUM_7SEGMENTS-1:0] i_value,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic                       o_req,
    output logic [ADDR_WIDTH-1:0]      o_addr,
    output logic [DATA_WIDTH-1:0]      o_wdata,
    input  logic                       i_ack,
    output logic                       o_busy,
    output logic                       o_done
);

    // state | meaning
    // IDLE  | ready for a new update, no bus request outstanding
    // WRITE | presenting one digit write on the bus, waiting for i_ack
    typedef enum logic {IDLE, WRITE} state_t;

    localparam int N     = NUM_7SEGMENTS;
    localparam int VW    = 4 * N;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t                 state_q, state_d;
    logic [VW-1:0]          pending_q, pending_d;
    logic [N-1:0]           dirty_q, dirty_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   req_q, req_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic [N-1:0]           dirty_new;
    logic [N-1:0]           remaining;
`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
    logic [VW-1:0]          shadow_q, shadow_d;
    logic                   shadow_valid_q, shadow_valid_d;
`endif

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] mask);
        lowest_set = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [3:0] nibble_at(input logic [VW-1:0] v, input logic [IDX_W-1:0] idx);
        nibble_at = '0;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == idx) nibble_at = v[4*i +: 4];
        end
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx);
        logic [ADDR_WIDTH-1:0] off;
        off     = ADDR_WIDTH'(idx) << 2;
        addr_of = BASE_ADDR + off;
    endfunction

`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
    always_comb begin
        dirty_new = '0;
        for (int i = 0; i < N; i++) begin
            dirty_new[i] = ~shadow_valid_q | (i_value[4*i +: 4] != shadow_q[4*i +: 4]);
        end
    end
`else
    always_comb begin
        dirty_new = '1;
    end
`endif

    always_comb begin
        remaining = dirty_q;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == idx_q) remaining[i] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dirty_d   = dirty_q;
        idx_d     = idx_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    pending_d = i_value;
                    if (dirty_new != '0) begin
                        state_d = WRITE;
                        dirty_d = dirty_new;
                        idx_d   = lowest_set(dirty_new);
                        req_d   = 1'b1;
                        addr_d  = addr_of(idx_d);
                        wdata_d = DATA_WIDTH'(nibble_at(i_value, idx_d));
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (i_ack) begin
`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
                    for (int i = 0; i < N; i++) begin
                        if (IDX_W'(i) == idx_q) shadow_d[4*i +: 4] = pending_q[4*i +: 4];
                    end
`endif
                    dirty_d = remaining;
                    if (remaining != '0) begin
                        idx_d   = lowest_set(remaining);
                        addr_d  = addr_of(idx_d);
                        wdata_d = DATA_WIDTH'(nibble_at(pending_q, idx_d));
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
                        shadow_valid_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            dirty_q   <= '0;
            idx_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dirty_q   <= dirty_d;
            idx_q     <= idx_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
`endif
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == WRITE);
    assign o_req   = req_q;
    assign o_addr  = addr_q;
    assign o_wdata = wdata_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_seg7_update_sequencer.sv
// Randomized self-checking bench for seg7_update_sequencer, compared against a per-digit display model.
module tb_seg7_update_sequencer;

`ifdef SEG7_UPDATE_SKIP_UNCHANGED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] i_value;
    logic        i_valid;
    logic        o_ready;
    logic        o_req;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic        i_ack;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_shadow [8];
    bit         m_valid;

    seg7_update_sequencer dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_value (i_value),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_req   (o_req),
        .o_addr  (o_addr),
        .o_wdata (o_wdata),
        .i_ack   (i_ack),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_shadow[i] = 4'h0;
    endtask

    // abort_at >= 0 pulses n_rst during that write instead of acking it
    task automatic do_update(input logic [31:0] v, input int dly, input bit pulse_busy, input int abort_at);
        logic [31:0] ea [$];
        logic [31:0] ed [$];
        logic [3:0]  nib;
        for (int i = 0; i < 8; i++) begin
            nib = v[4*i +: 4];
            if (!SKIP || !m_valid || nib != m_shadow[i]) begin
                ea.push_back(32'hc0001000 + 32'(4 * i));
                ed.push_back(32'(nib));
            end
        end
        @(negedge clk);
        check_eq("ready_before", o_ready, 1);
        i_value = v;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        if (ea.size() == 0) begin
            check_eq("empty_done", o_done, 1);
            check_eq("empty_req", o_req, 0);
            check_eq("empty_ready", o_ready, 1);
            @(negedge clk);
            check_eq("empty_done_clr", o_done, 0);
            return;
        end
        for (int k = 0; k < ea.size(); k++) begin
            check_eq("req", o_req, 1);
            check_eq("addr", o_addr, ea[k]);
            check_eq("wdata", o_wdata, ed[k]);
            check_eq("busy", {o_busy, o_ready}, 2'b10);
            check_eq("done_mid", o_done, 0);
            if (k == abort_at) begin
                n_rst = 1'b0;
                @(negedge clk);
                n_rst = 1'b1;
                check_eq("rst_req", o_req, 0);
                check_eq("rst_ready", {o_ready, o_busy, o_done}, 3'b100);
                check_eq("rst_addr", o_addr, 0);
                check_eq("rst_wdata", o_wdata, 0);
                model_reset();
                return;
            end
            for (int d = 0; d < dly; d++) begin
                if (pulse_busy) begin
                    i_valid = 1'b1;
                    i_value = $urandom;
                end
                @(negedge clk);
                i_valid = 1'b0;
                check_eq("hold_req", o_req, 1);
                check_eq("hold_addr", o_addr, ea[k]);
                check_eq("hold_wdata", o_wdata, ed[k]);
            end
            i_ack = 1'b1;
            @(negedge clk);
            i_ack = 1'b0;
        end
        check_eq("done", o_done, 1);
        check_eq("end_ready", o_ready, 1);
        check_eq("end_req", o_req, 0);
        for (int i = 0; i < 8; i++) m_shadow[i] = v[4*i +: 4];
        m_valid = 1'b1;
        @(negedge clk);
        check_eq("done_clr", o_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        logic [31:0] v;
        n_rst   = 1'b0;
        i_value = '0;
        i_valid = 1'b0;
        i_ack   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_ready", {o_ready, o_busy, o_done, o_req}, 4'b1000);
        check_eq("reset_addr", o_addr, 0);
        check_eq("reset_wdata", o_wdata, 0);
        n_rst = 1'b1;

        do_update(32'h12345678, 0, 1'b0, -1);
        do_update(32'h12345698, 0, 1'b0, -1);
        do_update(32'h12345698, 0, 1'b0, -1);
        do_update(32'hdeadbeef, 3, 1'b1, -1);

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_ack = 1'b1;
            @(negedge clk);
            i_ack = 1'b0;
            check_eq("spur_ack", {o_req, o_done, o_ready}, 3'b001);
        end

        do_update(32'h87654321, 0, 1'b0, -1);
        do_update(32'h12345678, 1, 1'b0, 3);
        do_update(32'h12345678, 0, 1'b0, -1);
        do_update(32'h12345678, 0, 1'b0, -1);

        prev = 32'h12345678;
        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = prev;
                default: v = prev ^ (32'hf << (4 * $urandom_range(0, 7)));
            endcase
            do_update(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
            prev = v;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
